// File: rtl/add_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : add_share_pkg
//  Purpose : Shared constants and types for the shared-adder arbiter.
//            ADD_W       - datapath width of the shared adder
//            arb_state_t - arbiter state (no owner / owner locked)
//  Rev     : 1.0  initial release
// ============================================================================
package add_share_pkg;

    localparam int ADD_W = 16;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage : add_share_pkg
`default_nettype wire

// File: rtl/add_share_arb_prefix_add16.sv
`default_nettype none
// ============================================================================
//  Module  : prefix_add16
//  Purpose : Combinational 16-bit Brent-Kung parallel-prefix adder.
//  Ports   : a_i, b_i  - operands
//            cin_i     - carry-in
//            sum_o     - a + b + cin, low 16 bits
//            cout_o    - carry-out (bit 16)
//  Rev     : 1.0  initial release
// ============================================================================
module prefix_add16
    import add_share_pkg::*;
(
    input  logic [ADD_W-1:0] a_i,
    input  logic [ADD_W-1:0] b_i,
    input  logic             cin_i,
    output logic [ADD_W-1:0] sum_o,
    output logic             cout_o
);

    logic [ADD_W-1:0] w_g;
    logic [ADD_W-1:0] w_p;
    logic [ADD_W-1:0] w_gg;   // group generate, ends as prefix [0..i]
    logic [ADD_W-1:0] w_pp;   // group propagate, ends as prefix [0..i]
    logic [ADD_W:0]   w_c;

    always_comb begin
        w_g  = a_i & b_i;
        w_p  = a_i ^ b_i;
        w_gg = w_g;
        w_pp = w_p;
        // Up-sweep: build power-of-two spans ending at 2d-1, 4d-1, ...
        for (int d = 1; d < ADD_W; d = d * 2) begin
            for (int i = 2 * d - 1; i < ADD_W; i = i + 2 * d) begin
                w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
                w_pp[i] = w_pp[i] & w_pp[i-d];
            end
        end
        // Down-sweep: fill in the remaining prefixes from finished ones
        for (int d = ADD_W / 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < ADD_W; i = i + 2 * d) begin
                w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
                w_pp[i] = w_pp[i] & w_pp[i-d];
            end
        end
        // Carry-in folds in through the full-prefix propagate
        w_c[0] = cin_i;
        for (int i = 0; i < ADD_W; i++) begin
            w_c[i+1] = w_gg[i] | (w_pp[i] & cin_i);
        end
        sum_o  = w_p ^ w_c[ADD_W-1:0];
        cout_o = w_c[ADD_W];
    end

endmodule : prefix_add16
`default_nettype wire

// File: rtl/add_share_arb.sv
`default_nettype none
// ============================================================================
//  Module  : add_share_arb
//  Purpose : Round-robin arbiter/sequencer sharing one 16-bit adder among
//            NREQ requesters; multi-beat transactions (LSW first) keep the
//            adder locked and chain the carry between beats.
//  Ports   : clk, rst                 - clock, async active-high reset
//            req_valid_i/req_ready_o  - per-requester beat handshake
//            req_a_i/req_b_i          - packed operands, requester i at [16i+:16]
//            req_cin_i                - carry-in (first beat only)
//            req_last_i               - final beat of transaction
//            res_valid_o/res_ready_i  - result handshake
//            res_sum_o/res_cout_o     - registered sum / carry-out
//            res_id_o/res_last_o      - issuing requester / last flag
//  Rev     : 1.0  initial release
// ============================================================================
module add_share_arb
    import add_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*ADD_W-1:0] req_a_i,
    input  logic [NREQ*ADD_W-1:0] req_b_i,
    input  logic [NREQ-1:0]       req_cin_i,
    input  logic [NREQ-1:0]       req_last_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [ADD_W-1:0]      res_sum_o,
    output logic                  res_cout_o,
    output logic [IDW-1:0]        res_id_o,
    output logic                  res_last_o
);

    arb_state_t       state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   rr_ptr_d;
    logic [IDW-1:0]   owner_q;
    logic             carry_q;
    logic             res_valid_q;
    logic [ADD_W-1:0] res_sum_q;
    logic             res_cout_q;
    logic [IDW-1:0]   res_id_q;
    logic             res_last_q;

    logic [IDW:0]     w_pick;
    logic             w_grant_found;
    logic [IDW-1:0]   w_gid;
    logic             w_slot_free;
    logic             w_accept;
    logic [ADD_W-1:0] w_a;
    logic [ADD_W-1:0] w_b;
    logic             w_cin;
    logic [ADD_W-1:0] sum_d;
    logic             cout_d;

    // Rotating priority encoder: first valid at or above ptr, wrapping.
    // Returns {found, index}. Scanned high-to-low so the lowest offset wins.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0]   pick;
        logic [IDW-1:0] sel;
        int             idx;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            sel = idx[IDW-1:0];
            if (v[sel]) begin
                pick = {1'b1, sel};
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_pick = rr_pick(req_valid_i, rr_ptr_q);
        if (state_q == ARB_LOCK) begin
            w_grant_found = 1'b1;
            w_gid         = owner_q;
        end else begin
            w_grant_found = w_pick[IDW];
            w_gid         = w_pick[IDW-1:0];
        end
    end

    assign w_slot_free = !res_valid_q || res_ready_i;
    // Reset gates the handshake so nothing is reported as taken while held.
    assign w_accept    = !rst && w_grant_found && req_valid_i[w_gid] && w_slot_free;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = w_accept && (w_gid == IDW'(i));
        end
    end

    assign w_a      = req_a_i[int'(w_gid)*ADD_W +: ADD_W];
    assign w_b      = req_b_i[int'(w_gid)*ADD_W +: ADD_W];
    // First beat takes the requester's carry-in; later beats chain carry_q.
    assign w_cin    = (state_q == ARB_IDLE) ? req_cin_i[w_gid] : carry_q;
    assign rr_ptr_d = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;

    prefix_add16 u_add (
        .a_i    (w_a),
        .b_i    (w_b),
        .cin_i  (w_cin),
        .sum_o  (sum_d),
        .cout_o (cout_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= '0;
            res_last_q  <= 1'b0;
        end else if (w_accept) begin
            // A load here also covers the drain of the previous result.
            res_valid_q <= 1'b1;
            res_sum_q   <= sum_d;
            res_cout_q  <= cout_d;
            res_id_q    <= w_gid;
            res_last_q  <= req_last_i[w_gid];
            carry_q     <= cout_d;
            if (req_last_i[w_gid]) begin
                state_q  <= ARB_IDLE;
                rr_ptr_q <= rr_ptr_d;
            end else begin
                state_q  <= ARB_LOCK;
                owner_q  <= w_gid;
            end
        end else if (res_valid_q && res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_sum_o   = res_sum_q;
    assign res_cout_o  = res_cout_q;
    assign res_id_o    = res_id_q;
    assign res_last_o  = res_last_q;

endmodule : add_share_arb
`default_nettype wire

// File: tb/tb_add_share_arb.sv
`default_nettype none
// ============================================================================
//  Module  : tb_add_share_arb
//  Purpose : Self-checking bench for add_share_arb: directed scenarios plus
//            randomized traffic against a behavioural transaction model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_add_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*16-1:0]   req_a;
    logic [NREQ*16-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
    logic [NREQ-1:0]      req_last;
    logic                 res_valid;
    logic                 res_ready;
    logic [15:0]          res_sum;
    logic                 res_cout;
    logic [IDW-1:0]       res_id;
    logic                 res_last;

    add_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_cin_i   (req_cin),
        .req_last_i  (req_last),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_sum_o   (res_sum),
        .res_cout_o  (res_cout),
        .res_id_o    (res_id),
        .res_last_o  (res_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the adder, where the rotation starts,
    // the pending inter-beat carry and the contents of the result slot.
    bit m_lock;
    int m_owner;
    int m_ptr;
    int m_carry;
    bit m_rv;
    int m_sum;
    int m_cout;
    int m_id;
    int m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_owner = 0; m_ptr = 0; m_carry = 0;
        m_rv = 0; m_sum = 0; m_cout = 0; m_id = 0; m_last = 0;
    endtask

    task automatic beat(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic last);
        req_valid[i]       = 1'b1;
        req_a[i*16 +: 16]  = a;
        req_b[i*16 +: 16]  = b;
        req_cin[i]         = cin;
        req_last[i]        = last;
    endtask

    // One clock: check handshake before the edge, advance the model, check
    // the result registers just after the edge.
    task automatic step();
        bit found;
        bit acc;
        int g;
        int s;
        int lst;
        #1;
        found = 0;
        g     = 0;
        if (m_lock) begin
            found = 1;
            g     = m_owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                    found = 1;
                    g     = (m_ptr + k) % NREQ;
                end
            end
        end
        acc = found && req_valid[g] && (!m_rv || res_ready);
        chk("req_ready", {28'd0, req_ready}, acc ? (32'd1 << g) : 32'd0);
        s   = int'(req_a[g*16 +: 16]) + int'(req_b[g*16 +: 16])
            + (m_lock ? m_carry : int'(req_cin[g]));
        lst = int'(req_last[g]);
        @(posedge clk);
        if (acc) begin
            m_rv    = 1;
            m_sum   = s % 65536;
            m_cout  = s / 65536;
            m_carry = s / 65536;
            m_id    = g;
            m_last  = lst;
            if (lst != 0) begin
                m_lock = 0;
                m_ptr  = (g + 1) % NREQ;
            end else begin
                m_lock  = 1;
                m_owner = g;
            end
        end else if (m_rv && res_ready) begin
            m_rv = 0;
        end
        #1;
        chk("res_valid", {31'd0, res_valid}, m_rv);
        chk("res_sum",   {16'd0, res_sum},   m_sum);
        chk("res_cout",  {31'd0, res_cout},  m_cout);
        chk("res_id",    {30'd0, res_id},    m_id);
        chk("res_last",  {31'd0, res_last},  m_last);
    endtask

    // Asynchronous reset applied between edges; requests stay up to confirm
    // the handshake is suppressed while reset is held.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_res_sum",   {16'd0, res_sum},   0);
        chk("rst_res_id",    {30'd0, res_id},    0);
        chk("rst_req_ready", {28'd0, req_ready}, 0);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_last  = '0;
        res_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        req_valid = 4'hF;
        do_reset();

        // Round-robin: everyone valid with single beats
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NREQ; i++) beat(i, 16'(k * 16 + i), 16'h0100, 1'b0, 1'b1);
            step();
            chk("rr_id", {30'd0, res_id}, k % 4);
        end

        // Single beat from requester 2
        req_valid = '0;
        beat(2, 16'h1234, 16'h0FFF, 1'b1, 1'b1);
        step();
        chk("sb_sum",  {16'd0, res_sum},  32'h2234);
        chk("sb_cout", {31'd0, res_cout}, 0);
        chk("sb_id",   {30'd0, res_id},   2);
        chk("sb_last", {31'd0, res_last}, 1);
        // Pointer now 3: requester 3 outranks requester 0
        req_valid = '0;
        beat(0, 16'h0001, 16'h0001, 1'b0, 1'b1);
        beat(3, 16'h0002, 16'h0002, 1'b0, 1'b1);
        step();
        chk("sb_ptr3", {30'd0, res_id}, 3);

        // 48-bit add on requester 0
        req_valid = '0;
        beat(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step();
        chk("mp0_sum",  {16'd0, res_sum},  32'h0000);
        chk("mp0_cout", {31'd0, res_cout}, 1);
        beat(0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        step();
        chk("mp1_sum",  {16'd0, res_sum},  32'h0000);
        chk("mp1_cout", {31'd0, res_cout}, 1);
        beat(0, 16'h0001, 16'h0000, 1'b0, 1'b1);
        step();
        chk("mp2_sum",  {16'd0, res_sum},  32'h0002);
        chk("mp2_cout", {31'd0, res_cout}, 0);
        chk("mp2_id",   {30'd0, res_id},   0);

        // Lock: owner 1 stalls, requester 3 must wait
        req_valid = '0;
        beat(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step();
        req_valid[1] = 1'b0;
        beat(3, 16'h0040, 16'h0004, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lock_rdy3", {31'd0, req_ready[3]}, 0);
        end
        beat(1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step();
        chk("lock_carry", {16'd0, res_sum}, 32'h0001);
        chk("lock_id",    {30'd0, res_id},  1);
        req_valid[1] = 1'b0;
        step();
        chk("lock_then3", {30'd0, res_id}, 3);

        // Backpressure
        req_valid = '0;
        beat(0, 16'h0010, 16'h0020, 1'b0, 1'b1);
        step();
        req_valid = '0;
        res_ready = 1'b0;
        beat(2, 16'h0100, 16'h0200, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_hold",  {16'd0, res_sum},   32'h0030);
            chk("bp_ready", {28'd0, req_ready}, 0);
        end
        res_ready = 1'b1;
        step();
        chk("bp_valid", {31'd0, res_valid}, 1);
        chk("bp_sum",   {16'd0, res_sum},   32'h0300);

        // Reset between beats of a 2-beat transaction
        req_valid = '0;
        beat(1, 16'h0005, 16'h0005, 1'b0, 1'b1);
        step();
        req_valid = '0;
        beat(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step();
        do_reset();
        beat(1, 16'h0001, 16'h0001, 1'b0, 1'b1);
        beat(2, 16'h0001, 16'h0001, 1'b0, 1'b1);
        step();
        chk("rst_ptr_id", {30'd0, res_id}, 1);
        req_valid = '0;
        beat(2, 16'h0001, 16'h0001, 1'b0, 1'b1);
        step();
        chk("rst_cin", {16'd0, res_sum}, 32'h0002);
        chk("rst_cin_id", {30'd0, res_id}, 2);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i]      = ($urandom_range(0, 3) != 0);
                req_a[i*16 +: 16] = 16'($urandom);
                req_b[i*16 +: 16] = 16'($urandom);
                req_cin[i]        = 1'($urandom_range(0, 1));
                req_last[i]       = 1'($urandom_range(0, 1));
            end
            res_ready = ($urandom_range(0, 3) != 0);
            if (n == 200) begin
                do_reset();
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_add_share_arb
`default_nettype wire
